// File: rtl/data_memory_sized.sv
// Data memory for the MIPS MEM stage: byte/half/word loads and stores,
// sign/zero-extended sub-word loads, registered read with a valid strobe,
// alignment checking, and a post-reset clear sequencer that zeroes the
// array one word per cycle so the storage maps onto block RAM.
module data_memory_sized #(
    parameter int RAM_SIZE_BIT   = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic [31:0] Read_data,
    output logic        Read_valid,
    output logic        Misaligned,
    output logic        Busy
);
    localparam int DEPTH = 1 << RAM_SIZE_BIT;

    typedef enum logic [0:0] {S_CLEAR, S_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [RAM_SIZE_BIT-1:0] clr_ptr_q, clr_ptr_d;
    logic [31:0]             mem_q [DEPTH];

    logic [31:0] Read_data_q, Read_data_d;
    logic        Read_valid_q, Read_valid_d;
    logic        Misaligned_q, Misaligned_d;

    // single write port shared by the clear sequencer and stores
    logic                    mem_we;
    logic [RAM_SIZE_BIT-1:0] mem_addr;
    logic [3:0]              mem_be;
    logic [31:0]             mem_wdata;

    logic [RAM_SIZE_BIT-1:0] word_idx;
    logic [1:0]              lane;
    logic                    legal, accept, do_read, do_write;
    logic [3:0]              st_be;
    logic [31:0]             st_data, rd_word, ld_ext;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic                    unused_addr;

    // address bits above the array are ignored so accesses wrap
    assign word_idx    = Address[RAM_SIZE_BIT+1:2];
    assign lane        = Address[1:0];
    assign unused_addr = ^Address[31:RAM_SIZE_BIT+2];

    // state register and clear pointer; reset restarts the clear from word 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // next state: walk the clear pointer, leave CLEAR after the last word
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == S_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (&clr_ptr_q) state_d = S_IDLE;
        end
    end

    // request decode: alignment, lane enables and replicated store data
    always_comb begin
        legal   = 1'b0;
        st_be   = 4'b0000;
        st_data = Write_data;
        unique case (MemSize)
            2'b00: begin
                legal   = 1'b1;
                st_be   = 4'b0001 << lane;
                st_data = {4{Write_data[7:0]}};
            end
            2'b01: begin
                legal   = ~lane[0];
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{Write_data[15:0]}};
            end
            2'b10: begin
                legal   = (lane == 2'b00);
                st_be   = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
        accept   = (state_q == S_IDLE) && (MemRead || MemWrite);
        do_read  = accept && legal && MemRead;
        do_write = accept && legal && MemWrite;
    end

    // FSM outputs: Busy and the write-port mux (clear writes win in CLEAR)
    always_comb begin
        Busy      = (state_q == S_CLEAR);
        mem_we    = do_write;
        mem_addr  = word_idx;
        mem_be    = st_be;
        mem_wdata = st_data;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end
    end

    // storage with per-byte write enables; no reset so it maps to RAM
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // load extraction from the pre-write word (read-first) plus extension
    always_comb begin
        rd_word = mem_q[word_idx];
        ld_byte = rd_word[8*lane +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (MemSize)
            2'b00:   ld_ext = {{24{MemSigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{MemSigned & ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase
        Read_data_d  = do_read ? ld_ext : Read_data_q;
        Read_valid_d = do_read;
        Misaligned_d = accept && !legal;
    end

    // registered load result and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Read_data_q  <= '0;
            Read_valid_q <= 1'b0;
            Misaligned_q <= 1'b0;
        end else begin
            Read_data_q  <= Read_data_d;
            Read_valid_q <= Read_valid_d;
            Misaligned_q <= Misaligned_d;
        end
    end

    assign Read_data  = Read_data_q;
    assign Read_valid = Read_valid_q;
    assign Misaligned = Misaligned_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized with a 16-word array.
module tb_data_memory_sized;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [31:0] Read_data;
    logic        Read_valid, Misaligned, Busy;

    int ntot  = 0;
    int nfail = 0;

    data_memory_sized #(.RAM_SIZE_BIT(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .Read_data  (Read_data),
        .Read_valid (Read_valid),
        .Misaligned (Misaligned),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] data);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn;
        Address = addr; Write_data = data;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    // counts Busy-high cycles after release, driving a store+load at 0x4
    // the whole time, and checks those requests are ignored
    task automatic count_clear(input string tag);
        int  cnt;
        logic stray;
        cnt   = 0;
        stray = 1'b0;
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_FFFF);
        while (Busy && cnt < 40) begin
            cnt++;
            tick();
            stray = stray | Read_valid | Misaligned;
        end
        idle();
        check({tag, "_busy_cycles"}, cnt, 32'd16);
        check({tag, "_busy_ignored"}, {31'b0, stray}, 32'b0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) tick();
        check("rst_busy",  {31'b0, Busy}, 32'd1);
        check("rst_valid", {31'b0, Read_valid}, 32'd0);
        check("rst_mis",   {31'b0, Misaligned}, 32'd0);
        check("rst_rdata", Read_data, 32'h0);

        reset = 1'b1;
        count_clear("clear1");

        // every word reads back zero, back-to-back
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
            tick();
            check($sformatf("clr_valid_%0d", i), {31'b0, Read_valid}, 32'd1);
            check($sformatf("clr_data_%0d", i), Read_data, 32'h0);
        end
        idle();
        tick();
        check("valid_drop", {31'b0, Read_valid}, 32'd0);

        // byte/half stores merged into a word
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344); tick();
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'hA, 32'h5555_55AB); tick();
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h8, 32'h6666_BEEF); tick();
        check("store_no_valid", {31'b0, Read_valid}, 32'd0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0); tick();
        check("merge_word", Read_data, 32'h11AB_BEEF);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'hA, 32'h0); tick();
        check("lb_signed", Read_data, 32'hFFFF_FFAB);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h8, 32'h0); tick();
        check("lhu", Read_data, 32'h0000_BEEF);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h8, 32'h0); tick();
        check("lh_signed", Read_data, 32'hFFFF_BEEF);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'hB, 32'h0); tick();
        check("lbu_lane3", Read_data, 32'h0000_0011);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0); tick();
        check("lh_upper_pos", Read_data, 32'h0000_11AB);
        req(1'b1, 1'b0, 2'b10, 1'b1, 32'h8, 32'h0); tick();
        check("lw_ignores_sign", Read_data, 32'h11AB_BEEF);
        idle(); tick();
        check("hold_data", Read_data, 32'h11AB_BEEF);

        // misaligned requests
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_7777); tick();
        check("mis_sh", {31'b0, Misaligned}, 32'd1);
        check("mis_sh_valid", {31'b0, Read_valid}, 32'd0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0); tick();
        check("mis_sh_unchanged", Read_data, 32'h0);
        check("mis_pulse_end", {31'b0, Misaligned}, 32'd0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0); tick();
        check("mis_lw", {31'b0, Misaligned}, 32'd1);
        check("mis_lw_valid", {31'b0, Read_valid}, 32'd0);
        req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0); tick();
        check("mis_size11", {31'b0, Misaligned}, 32'd1);

        // read-first on simultaneous load and store
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D); tick();
        check("rf_valid", {31'b0, Read_valid}, 32'd1);
        check("rf_old", Read_data, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); tick();
        check("rf_new", Read_data, 32'hCAFE_F00D);

        // address wrap above the array
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678); tick();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0); tick();
        check("wrap", Read_data, 32'h1234_5678);
        idle(); tick();

        // reset in the middle of a clear restarts it
        reset = 1'b0; #1;
        check("async_rst_rdata", Read_data, 32'h0);
        tick();
        reset = 1'b1;
        repeat (7) tick();
        check("midclear_busy", {31'b0, Busy}, 32'd1);
        reset = 1'b0;
        tick();
        check("midclear_rst_busy", {31'b0, Busy}, 32'd1);
        reset = 1'b1;
        count_clear("clear2");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0); tick();
        check("reclear_w0", Read_data, 32'h0);
        check("reclear_w0_valid", {31'b0, Read_valid}, 32'd1);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0); tick();
        check("reclear_w2", Read_data, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0); tick();
        check("reclear_w15", Read_data, 32'h0);
        idle(); tick();

        $display("%0d/%0d checks passed", ntot - nfail, ntot);
        $finish;
    end
endmodule
